// File: rtl/x_demux_ddr_align_alct_pkg.sv
// Shared definitions for the ALCT DDR alignment back end: FSM state encodings,
// default training words and the pipeline settle length.
package x_demux_ddr_align_alct_pkg;

    // Alignment FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StTry,
        StLocked,
        StFail
    } align_state_e;

    // Default training words, 1st and 2nd in time.
    localparam logic [15:0] PAT1ST_DEFAULT = 16'h5A3C;
    localparam logic [15:0] PAT2ND_DEFAULT = 16'hA5C3;

    // Cycles needed to flush slip stage, deepest delay tap and output register.
    function automatic int unsigned settle_len(input int unsigned max_delay);
        return max_delay + 3;
    endfunction

endpackage

// File: rtl/x_delay_tap.sv
// Programmable whole-cycle delay: MAX_DELAY-deep shift register with a clamped
// tap select. Tap 0 is the undelayed input (combinational pass-through).
module x_delay_tap #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_DELAY = 15,
    parameter int unsigned DLY_W     = 4
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic [DLY_W-1:0] delay_sel,
    output logic [WIDTH-1:0] dout
);

    // sr[i] holds din delayed by i+1 cycles.
    logic [WIDTH-1:0] sr [MAX_DELAY];
    logic [DLY_W-1:0] tap;

    // Shift register, cleared on reset.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(MAX_DELAY); i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < int'(MAX_DELAY); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Clamp out-of-range selects to the deepest tap.
    always_comb begin
        tap = delay_sel;
        if (32'(delay_sel) > MAX_DELAY) begin
            tap = DLY_W'(MAX_DELAY);
        end
    end

    // Tap multiplexer.
    always_comb begin
        dout = din;
        for (int i = 1; i <= int'(MAX_DELAY); i++) begin
            if (32'(tap) == 32'(i)) begin
                dout = sr[i-1];
            end
        end
    end

endmodule

// File: rtl/x_demux_ddr_align_alct.sv
// ALCT DDR de-multiplexer back end: half-cycle slip (1st/2nd re-pairing) chosen
// by a training-pattern search, programmable whole-cycle delay, output register
// and a saturating mismatch counter once locked.
module x_demux_ddr_align_alct
    import x_demux_ddr_align_alct_pkg::*;
#(
    parameter int unsigned     WIDTH       = 16,
    parameter int unsigned     MAX_DELAY   = 15,
    parameter int unsigned     DLY_W       = 4,
    parameter logic [WIDTH-1:0] PAT1ST     = WIDTH'(PAT1ST_DEFAULT),
    parameter logic [WIDTH-1:0] PAT2ND     = WIDTH'(PAT2ND_DEFAULT),
    parameter int unsigned     LOCK_COUNT  = 64,
    parameter int unsigned     TRY_TIMEOUT = 1024,
    parameter int unsigned     ERR_W       = 16
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din1st,
    input  logic [WIDTH-1:0] din2nd,
    input  logic [DLY_W-1:0] delay_sel,
    input  logic             train_start,
    input  logic             train_en,
    output logic [WIDTH-1:0] dout1st,
    output logic [WIDTH-1:0] dout2nd,
    output logic             locked,
    output logic             train_fail,
    output logic             slip,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned SETTLE_LEN = settle_len(MAX_DELAY);
    localparam int unsigned SETTLE_W   = $clog2(SETTLE_LEN + 1);
    localparam int unsigned GOOD_W     = $clog2(LOCK_COUNT + 1);
    localparam int unsigned TMO_W      = $clog2(TRY_TIMEOUT + 1);

    logic [WIDTH-1:0]   hold_q;
    logic [WIDTH-1:0]   s1_q;
    logic [WIDTH-1:0]   s2_q;
    logic [2*WIDTH-1:0] tap_out;

    align_state_e       state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic match;
    logic mismatch;

    // Slip stage: with slip set, the previous 2nd word pairs as 1st with the current 1st word.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            hold_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            hold_q <= din2nd;
            if (slip) begin
                s1_q <= hold_q;
                s2_q <= din1st;
            end else begin
                s1_q <= din1st;
                s2_q <= din2nd;
            end
        end
    end

    x_delay_tap #(
        .WIDTH     (2 * WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .DLY_W     (DLY_W)
    ) u_delay_tap (
        .clock     (clock),
        .clr_n     (clr_n),
        .din       ({s1_q, s2_q}),
        .delay_sel (delay_sel),
        .dout      (tap_out)
    );

    // Output register.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            dout1st <= '0;
            dout2nd <= '0;
        end else begin
            dout1st <= tap_out[2*WIDTH-1:WIDTH];
            dout2nd <= tap_out[WIDTH-1:0];
        end
    end

    // Training comparison on the aligned output; nothing is judged while train_en is low.
    always_comb begin
        match    = train_en && (dout1st == PAT1ST) && (dout2nd == PAT2ND);
        mismatch = train_en && !match;
    end

    // Alignment FSM with registered status outputs; train_start overrides everything.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state      <= StIdle;
            slip       <= 1'b0;
            locked     <= 1'b0;
            train_fail <= 1'b0;
            err_cnt    <= '0;
            settle_cnt <= '0;
            good_cnt   <= '0;
            tmo_cnt    <= '0;
        end else if (train_start) begin
            state      <= StSettle;
            slip       <= 1'b0;
            locked     <= 1'b0;
            train_fail <= 1'b0;
            err_cnt    <= '0;
            settle_cnt <= '0;
            good_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                end
                StSettle: begin
                    if (32'(settle_cnt) == SETTLE_LEN - 1) begin
                        state      <= StTry;
                        settle_cnt <= '0;
                        good_cnt   <= '0;
                        tmo_cnt    <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StTry: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (match) begin
                        good_cnt <= good_cnt + 1'b1;
                    end else if (mismatch) begin
                        good_cnt <= '0;
                    end
                    // Lock wins over a timeout landing on the same cycle.
                    if (match && (32'(good_cnt) + 32'd1 == LOCK_COUNT)) begin
                        state  <= StLocked;
                        locked <= 1'b1;
                    end else if (32'(tmo_cnt) + 32'd1 == TRY_TIMEOUT) begin
                        if (!slip) begin
                            slip       <= 1'b1;
                            state      <= StSettle;
                            settle_cnt <= '0;
                        end else begin
                            slip       <= 1'b0;
                            train_fail <= 1'b1;
                            state      <= StFail;
                        end
                    end
                end
                StLocked: begin
                    if (mismatch && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                StFail: begin
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_demux_ddr_align_alct.sv
// Self-checking bench for the ALCT DDR alignment back end: reset, lock on an
// aligned and a swapped link, training failure, error counting/saturation and
// a table-driven latency sweep.
module tb_x_demux_ddr_align_alct;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DLY_W = 5;

    logic             clock;
    logic             clr_n;
    logic [WIDTH-1:0] din1st;
    logic [WIDTH-1:0] din2nd;
    logic [DLY_W-1:0] delay_sel;
    logic             train_start;
    logic             train_en;
    logic [WIDTH-1:0] dout1st;
    logic [WIDTH-1:0] dout2nd;
    logic             locked;
    logic             train_fail;
    logic             slip;
    logic [15:0]      err_cnt;

    int n_vec;
    int n_mis;

    typedef struct {
        logic [DLY_W-1:0] sel;
        int               exp_lat;
    } lat_vec_t;

    lat_vec_t vecs [18];

    x_demux_ddr_align_alct #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (15),
        .DLY_W     (DLY_W)
    ) dut (
        .clock       (clock),
        .clr_n       (clr_n),
        .din1st      (din1st),
        .din2nd      (din2nd),
        .delay_sel   (delay_sel),
        .train_start (train_start),
        .train_en    (train_en),
        .dout1st     (dout1st),
        .dout2nd     (dout2nd),
        .locked      (locked),
        .train_fail  (train_fail),
        .slip        (slip),
        .err_cnt     (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        train_start = 1'b1;
        step(1);
        train_start = 1'b0;
    endtask

    // Restart training on an aligned link and confirm lock at settle(18) + 64 edges.
    task automatic lock_aligned(input string tag);
        din1st   = 16'h5A3C;
        din2nd   = 16'hA5C3;
        train_en = 1'b1;
        pulse_start();
        step(81);
        check({tag, " locked before 82"}, 32'(locked), 32'd0);
        step(1);
        check({tag, " locked at 82"}, 32'(locked), 32'd1);
        check({tag, " slip"}, 32'(slip), 32'd0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] marker;

        n_vec = 0;
        n_mis = 0;

        vecs[0]  = '{sel: 5'd0,  exp_lat: 2};
        vecs[1]  = '{sel: 5'd1,  exp_lat: 3};
        vecs[2]  = '{sel: 5'd2,  exp_lat: 4};
        vecs[3]  = '{sel: 5'd3,  exp_lat: 5};
        vecs[4]  = '{sel: 5'd4,  exp_lat: 6};
        vecs[5]  = '{sel: 5'd5,  exp_lat: 7};
        vecs[6]  = '{sel: 5'd6,  exp_lat: 8};
        vecs[7]  = '{sel: 5'd7,  exp_lat: 9};
        vecs[8]  = '{sel: 5'd8,  exp_lat: 10};
        vecs[9]  = '{sel: 5'd9,  exp_lat: 11};
        vecs[10] = '{sel: 5'd10, exp_lat: 12};
        vecs[11] = '{sel: 5'd11, exp_lat: 13};
        vecs[12] = '{sel: 5'd12, exp_lat: 14};
        vecs[13] = '{sel: 5'd13, exp_lat: 15};
        vecs[14] = '{sel: 5'd14, exp_lat: 16};
        vecs[15] = '{sel: 5'd15, exp_lat: 17};
        vecs[16] = '{sel: 5'd20, exp_lat: 17};
        vecs[17] = '{sel: 5'd31, exp_lat: 17};

        clr_n       = 1'b0;
        din1st      = 16'hABCD;
        din2nd      = 16'h0F0F;
        delay_sel   = '0;
        train_start = 1'b0;
        train_en    = 1'b0;

        // 1. Reset mid-stream, then 2-cycle latency after release.
        step(3);
        clr_n = 1'b1;
        step(5);
        check("stream dout1st", 32'(dout1st), 32'hABCD);
        #2;
        clr_n = 1'b0;
        #1;
        check("async rst dout1st", 32'(dout1st), 32'd0);
        check("async rst dout2nd", 32'(dout2nd), 32'd0);
        check("async rst locked", 32'(locked), 32'd0);
        check("async rst fail", 32'(train_fail), 32'd0);
        check("async rst slip", 32'(slip), 32'd0);
        check("async rst err_cnt", 32'(err_cnt), 32'd0);
        step(2);
        clr_n  = 1'b1;
        din1st = 16'h1234;
        step(1);
        check("release +1 dout1st", 32'(dout1st), 32'd0);
        step(1);
        check("release +2 dout1st", 32'(dout1st), 32'h1234);

        // 2. Aligned link with delay 3.
        delay_sel = 5'd3;
        lock_aligned("aligned");
        check("aligned dout1st", 32'(dout1st), 32'h5A3C);
        check("aligned dout2nd", 32'(dout2nd), 32'hA5C3);

        // 3. Swapped link: slip 0 times out at 18+1024, slip 1 locks 82 edges later.
        din1st = 16'hA5C3;
        din2nd = 16'h5A3C;
        pulse_start();
        check("swap locked cleared", 32'(locked), 32'd0);
        step(1041);
        check("swap slip before timeout", 32'(slip), 32'd0);
        step(1);
        check("swap slip after timeout", 32'(slip), 32'd1);
        step(81);
        check("swap locked before", 32'(locked), 32'd0);
        step(1);
        check("swap locked", 32'(locked), 32'd1);
        check("swap slip held", 32'(slip), 32'd1);
        check("swap dout1st", 32'(dout1st), 32'h5A3C);
        check("swap dout2nd", 32'(dout2nd), 32'hA5C3);

        // 4. Garbage pattern: both slips time out.
        din1st = 16'hFFFF;
        din2nd = 16'hFFFF;
        pulse_start();
        step(2083);
        check("garbage fail before", 32'(train_fail), 32'd0);
        check("garbage slip before", 32'(slip), 32'd1);
        step(1);
        check("garbage fail", 32'(train_fail), 32'd1);
        check("garbage slip", 32'(slip), 32'd0);
        check("garbage locked", 32'(locked), 32'd0);
        step(5);
        check("fail holds", 32'(train_fail), 32'd1);
        check("fail passes data", 32'(dout1st), 32'hFFFF);

        // 5. Error counting while locked.
        lock_aligned("relock");
        din1st = 16'h0000;
        step(3);
        din1st = 16'h5A3C;
        step(10);
        check("err 3 corrupt", 32'(err_cnt), 32'd3);
        train_en = 1'b0;
        din1st   = 16'h0000;
        step(3);
        din1st = 16'h5A3C;
        step(10);
        train_en = 1'b1;
        step(2);
        check("err unchanged train_en=0", 32'(err_cnt), 32'd3);
        check("still locked", 32'(locked), 32'd1);
        din1st = 16'h0000;
        step(65536 + 5 + 10);
        check("err saturates", 32'(err_cnt), 32'hFFFF);
        din1st = 16'h5A3C;
        step(20);
        check("err stays saturated", 32'(err_cnt), 32'hFFFF);

        // 6. Latency sweep with a one-cycle marker word (slip is 0 here).
        train_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            delay_sel = vecs[i].sel;
            din1st    = 16'h0000;
            step(20);
            marker = 16'hC000 | 16'(i);
            din1st = marker;
            lat    = 0;
            for (int k = 1; k <= 30; k++) begin
                step(1);
                din1st = 16'h0000;
                if (lat == 0 && dout1st == marker) begin
                    lat = k;
                end
            end
            check($sformatf("latency sel=%0d", vecs[i].sel), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // train_start while locked: locked and err_cnt clear on the next edge.
        check("locked before restart", 32'(locked), 32'd1);
        pulse_start();
        check("restart locked", 32'(locked), 32'd0);
        check("restart err_cnt", 32'(err_cnt), 32'd0);
        check("restart fail", 32'(train_fail), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
